// File: rtl/piso_serializer.sv
// piso_serializer
//   Parametrised parallel-in serial-out shift register with a ready/valid
//   load handshake, downstream stall (shift_en) and frame-boundary flags.
//   Sits between a parallel word source and a serial line driver.
//
//   Parameters:
//     WIDTH     data word width (>= 2)
//     LSB_FIRST 1: bit 0 goes out first; 0: bit WIDTH-1 goes out first
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset, overrides everything
//     d          parallel word to load
//     load_valid source has a word on d
//     load_ready block accepts d this cycle (combinational)
//     shift_en   downstream consumes the current serial bit this cycle
//     so         serial data out (registered)
//     so_valid   so holds a valid bit
//     first      so is the first bit of the frame
//     last       so is the final bit of the frame
//     busy       frame in progress
//
//   Optional build macro:
//     PISO_PARITY_EN  append an even-parity bit (XOR of the word) after the
//                     data bits; the frame becomes WIDTH+1 bits and last
//                     marks the parity bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             bit_nxt;
  logic             bit_load;
  logic             at_last;
  logic             load;

  assign busy     = (state == S_SHIFT);
  assign so_valid = busy;
  assign at_last  = busy && (cnt == LAST_CNT);
  assign first    = busy && (cnt == '0);
  assign last     = at_last;

  // A new word is accepted while idle, or on the very edge that consumes the
  // final bit so frames can run back to back with no idle gap.
  assign load_ready = !busy || (at_last && shift_en);
  assign load       = load_valid && load_ready;

  // sreg always holds the word aligned so that the bit currently on so sits
  // at the output end; the next bit is therefore the neighbour after a shift.
  always_comb begin
    sreg_nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
    bit_nxt  = LSB_FIRST ? sreg_nxt[0] : sreg_nxt[WIDTH-1];
    bit_load = LSB_FIRST ? d[0] : d[WIDTH-1];
  end

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst)       par <= 1'b0;
    else if (load) par <= ^d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sreg  <= '0;
      so    <= 1'b0;
    end else if (load) begin
      state <= S_SHIFT;
      cnt   <= '0;
      sreg  <= d;
      so    <= bit_load;
    end else if (busy && shift_en) begin
      if (at_last) begin
        // frame done, nothing queued: park with so low
        state <= S_IDLE;
        cnt   <= '0;
        so    <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        sreg <= sreg_nxt;
`ifdef PISO_PARITY_EN
        // after the last data bit the stored parity goes out
        if (cnt == CW'(WIDTH - 1)) so <= par;
        else                       so <= bit_nxt;
`else
        so   <= bit_nxt;
`endif
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in serial-out shift register. Successor to the fixed 4-bit PISO in this codebase.
- Adds generic width, selectable bit order and a ready/valid load handshake.
- Adds a downstream stall input (shift_en) and frame-boundary flags.
- Sits between a parallel word source (FIFO or register bank) and a serial line driver.

Parameters:
- WIDTH, 8: data word width in bits. Must be >= 2.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- d  input  WIDTH  parallel word to load.
- load_valid  input  1  source has a word on d.
- load_ready  output  1  block accepts d this cycle (combinational).
- shift_en  input  1  downstream consumes the current serial bit this cycle.
- so  output  1  serial data out (registered).
- so_valid  output  1  so holds a valid bit.
- first  output  1  so is the first bit of the frame.
- last  output  1  so is the final bit of the frame.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- Single clock domain. rst is synchronous and active-high; it overrides all other inputs.
- Reset values: so=0, so_valid=0, first=0, last=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Two-state FSM:
  - IDLE: so_valid=0, so=0.
  - SHIFT: so_valid=1.
- load_ready = (state==IDLE) OR (state==SHIFT AND last AND shift_en).
- Load handshake: a load occurs when load_valid AND load_ready at a rising edge.
  - The register captures d. The counter clears to 0. The state becomes SHIFT.
  - The first bit appears on so the next cycle, with first=1.
  - Latency from load to first bit: 1 cycle.
- Bit selection: bit under count n is d[n] when LSB_FIRST=1, or d[WIDTH-1-n] when LSB_FIRST=0. Implement as a right or left shift of the register.
- Advance: in SHIFT with shift_en=1, the current bit is consumed and the counter increments. The next bit appears on the following cycle.
- Stall: in SHIFT with shift_en=0, so, first, last and the counter hold unchanged, for any number of cycles.
- Flags: first=1 only while counter==0. last=1 only while counter==WIDTH-1.
- End of frame: when last AND shift_en:
  - If load_valid=1, the next word is loaded in the same edge. There is no idle gap and busy stays 1, giving back-to-back frames.
  - Otherwise the state returns to IDLE, so_valid drops next cycle, and so is driven to 0.
- load_valid while busy and not at the last-bit consume: ignored, load_ready=0, the source must hold d.
- Changes on d outside a load handshake have no effect.
- Reset mid-frame: the frame is abandoned. All outputs take reset values at the next edge; no partial bits follow.
- Counter width is clog2(WIDTH+1) bits. It never wraps past the frame's final count.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the loaded word) is transmitted as an extra final bit after the WIDTH data bits.
  - last asserts on the parity bit, not on data bit WIDTH-1. The frame is WIDTH+1 bits.
  - The counter ranges 0..WIDTH. load_ready and back-to-back loading key off the parity bit.
  - Parity is computed at load time and stored in a dedicated flop.
- Undefined: the frame is exactly WIDTH bits. No parity logic is present.

Test Plan:
- WIDTH=8, LSB_FIRST=1, load d=8'hA5, shift_en=1 held. Required response:
  - so sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after the load.
  - first on cycle 1 only, last on cycle 8 only.
  - so_valid=0 and busy=0 from cycle 9.
- LSB_FIRST=0, load 8'hA5, shift_en=1. Required response: so sequence 1,0,1,0,0,1,0,1 read MSB first (bit7..bit0), matching 8'hA5.
- Back-to-back: load 8'hFF, then hold load_valid=1 with d=8'h00. Required response:
  - load_ready=1 exactly on the last-bit cycle.
  - Sixteen contiguous so_valid cycles: eight 1s then eight 0s, with no gap.
- Stall: load 8'h81, drop shift_en for 3 cycles while bit 3 is presented. Required response:
  - so=0 holds for 4 cycles with the counter frozen.
  - The frame completes with total so_valid duration of 11 cycles.
- Reset mid-frame: load 8'h3C, assert rst after 4 bits. Required response:
  - Next cycle so=0, so_valid=0, busy=0, load_ready=1.
  - A new load of 8'h01 then serialises cleanly.
- PISO_PARITY_EN defined: load 8'h07. Required response: 9 bits are sent, with the 9th bit=1 (odd count of ones) and last asserted on the 9th bit only.
